// File: rtl/xxx_req_ctrl.sv
// Requesting end of the xxx enable/data-valid link: captures a frame from the producer, then drains it downstream.
// Optional capture timeout is built in when XXX_REQ_TIMEOUT_EN is defined.
module xxx_req_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_SMP = 8,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic              clk_cg_i,
  input  logic              rst_b_i,
  input  logic              start_i,
  output logic              xxx_en_o,
  input  logic              xxx_dt_valid_i,
  input  logic [DATA_W-1:0] xxx_dt_i,
  output logic [DATA_W-1:0] frm_dt_o,
  output logic              frm_valid_o,
  input  logic              frm_ready_i,
  output logic              frm_last_o,
  output logic              busy_o,
  output logic              tmo_o
);

  localparam int unsigned CW = $clog2(NUM_SMP);
  localparam int unsigned GW = $clog2(GAP_CYC + 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SMP - 1);

  if (NUM_SMP < 2 || TMO_CYC < 1) begin : g_param_chk
    $error("xxx_req_ctrl: NUM_SMP must be >= 2 and TMO_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPT,
    S_REL,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     rd;
  logic [CW-1:0]     rd_nxt;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] smp_buf [NUM_SMP];
  logic              aborted;

`ifdef XXX_REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;

  assign tmo_o   = tmo_q;
  assign aborted = tmo_q;
`else
  assign tmo_o   = 1'b0;
  assign aborted = 1'b0;
`endif

  assign rd_nxt = rd + 1'b1;

  always_ff @(posedge clk_cg_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rd          <= '0;
      gap_cnt     <= '0;
      xxx_en_o    <= 1'b0;
      frm_valid_o <= 1'b0;
      frm_last_o  <= 1'b0;
      frm_dt_o    <= '0;
      busy_o      <= 1'b0;
      for (int unsigned i = 0; i < NUM_SMP; i++) smp_buf[i] <= '0;
`ifdef XXX_REQ_TIMEOUT_EN
      tmo_cnt     <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state    <= S_REQ;
            xxx_en_o <= 1'b1;
            busy_o   <= 1'b1;
            cnt      <= '0;
`ifdef XXX_REQ_TIMEOUT_EN
            tmo_q    <= 1'b0;
            tmo_cnt  <= '0;
`endif
          end
        end

        // REQ captures the first sample itself so CAPT always starts at index 1
        S_REQ, S_CAPT: begin
          if (xxx_dt_valid_i) begin
`ifdef XXX_REQ_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (state == S_REQ) begin
              smp_buf[0] <= xxx_dt_i;
              cnt        <= CW'(1);
              state      <= S_CAPT;
            end else begin
              smp_buf[cnt] <= xxx_dt_i;
              if (cnt == LAST_IDX) begin
                state    <= S_REL;
                xxx_en_o <= 1'b0;
                gap_cnt  <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end else begin
`ifdef XXX_REQ_TIMEOUT_EN
            if (tmo_cnt == TW'(TMO_CYC - 1)) begin
              tmo_q    <= 1'b1;
              state    <= S_REL;
              xxx_en_o <= 1'b0;
              gap_cnt  <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
        end

        S_REL: begin
          if (gap_cnt == GW'(GAP_CYC)) begin
            rd <= '0;
            if (aborted) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else begin
              state       <= S_DRAIN;
              frm_valid_o <= 1'b1;
              frm_dt_o    <= smp_buf[0];
              frm_last_o  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        // frm_valid_o is always high here, so ready alone marks a transfer
        S_DRAIN: begin
          if (frm_ready_i) begin
            if (frm_last_o) begin
              state       <= S_IDLE;
              frm_valid_o <= 1'b0;
              frm_last_o  <= 1'b0;
              busy_o      <= 1'b0;
            end else begin
              rd         <= rd_nxt;
              frm_dt_o   <= smp_buf[rd_nxt];
              frm_last_o <= (rd_nxt == LAST_IDX);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xxx_req_ctrl.sv
// Directed bench for xxx_req_ctrl: cycle table for a plain frame, then gapped, stalled, busy-start, timeout and reset sequences.
module tb_xxx_req_ctrl;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic        en;
  logic        dv;
  logic [15:0] dt;
  logic [15:0] fdt;
  logic        fv;
  logic        rdy;
  logic        flast;
  logic        busy;
  logic        tmo;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [15:0] frm [4];
  int unsigned en_low_run = 0;
  int unsigned last_gap   = 0;

  xxx_req_ctrl #(
    .DATA_W (16),
    .NUM_SMP(4),
    .GAP_CYC(2),
    .TMO_CYC(16)
  ) dut (
    .clk_cg_i      (clk),
    .rst_b_i       (rst_b),
    .start_i       (start),
    .xxx_en_o      (en),
    .xxx_dt_valid_i(dv),
    .xxx_dt_i      (dt),
    .frm_dt_o      (fdt),
    .frm_valid_o   (fv),
    .frm_ready_i   (rdy),
    .frm_last_o    (flast),
    .busy_o        (busy),
    .tmo_o         (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // length of the most recent low stretch of the enable, taken on each rise
  always @(negedge clk) begin
    if (en) begin
      if (en_low_run != 0) last_gap = en_low_run;
      en_low_run = 0;
    end else begin
      en_low_run = en_low_run + 1;
    end
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] dt;
    logic        en;
    logic        fv;
    logic [15:0] fdt;
    logic        last;
    logic        busy;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t v(input logic s, input logic vl, input logic [15:0] d,
                             input logic e, input logic f, input logic [15:0] fd,
                             input logic l, input logic b);
    vec_t r;
    r.start = s; r.valid = vl; r.dt = d; r.en = e;
    r.fv = f; r.fdt = fd; r.last = l; r.busy = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},    en,    0);
    chk({tag, "_fv"},    fv,    0);
    chk({tag, "_last"},  flast, 0);
    chk({tag, "_busy"},  busy,  0);
    chk({tag, "_tmo"},   tmo,   0);
    chk({tag, "_fdt"},   fdt,   0);
  endtask

  // asynchronous reset asserted away from any clock edge
  task automatic reset_pulse(input string tag);
    #2;
    rst_b = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    start = 1'b0; dv = 1'b0; dt = '0;
    rst_b = 1'b1;
  endtask

  // start a request and act as producer: valid from the 3rd edge of enable
  task automatic capture(input bit gapped, input bit poke);
    int unsigned got = 0;
    int unsigned cyc = 0;
    bit tog = 1'b1;
    start = 1'b1;
    step;
    chk("req_latency_en", en, 1);
    start = poke;
    step;
    start = 1'b0;
    step;
    chk("req_wait_en", en, 1);
    while (got < 4 && cyc < 40) begin
      dv  = gapped ? tog : 1'b1;
      dt  = frm[got];
      tog = !tog;
      step;
      cyc++;
      if (dv) got++;
      chk("capt_en", en, (got < 4) ? 1 : 0);
      chk("capt_busy", busy, 1);
    end
    dv = 1'b0;
    dt = '0;
    chk("capt_count", got, 4);
  endtask

  task automatic drain(input bit toggle_rdy, input bit poke, input int unsigned tail);
    int unsigned got = 0;
    int unsigned cyc = 0;
    logic        pfv, plast, prdy;
    logic [15:0] pdt;
    while (got < 4 && cyc < 40) begin
      rdy   = toggle_rdy ? logic'(cyc % 2) : 1'b1;
      start = poke && (cyc == 3 || cyc == 6);
      dv    = 1'b1;
      pfv = fv; pdt = fdt; plast = flast; prdy = rdy;
      step;
      cyc++;
      start = 1'b0;
      chk("drain_en", en, 0);
      if (pfv && prdy) begin
        chk("drain_dt", pdt, frm[got]);
        chk("drain_last", plast, (got == 3) ? 1 : 0);
        got++;
      end else if (pfv) begin
        chk("stall_dt", fdt, pdt);
        chk("stall_last", flast, plast);
        chk("stall_valid", fv, 1);
      end
    end
    dv  = 1'b0;
    rdy = 1'b1;
    chk("drain_count", got, 4);
    chk("drain_busy_low", busy, 0);
    chk("drain_valid_low", fv, 0);
    for (int unsigned i = 0; i < tail; i++) begin
      step;
      chk("no_extra_valid", fv, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned en_hi;
    rst_b = 1'b0; start = 1'b0; dv = 1'b0; dt = '0; rdy = 1'b1;

    tbl[0]  = v(1'b1, 1'b0, 16'h0,  1'b1, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[1]  = v(1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[2]  = v(1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[3]  = v(1'b0, 1'b1, 16'hA1, 1'b1, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[4]  = v(1'b0, 1'b1, 16'hA2, 1'b1, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[5]  = v(1'b0, 1'b1, 16'hA3, 1'b1, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[6]  = v(1'b0, 1'b1, 16'hA4, 1'b0, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[7]  = v(1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[8]  = v(1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b0, 1'b1);
    tbl[9]  = v(1'b0, 1'b0, 16'h0,  1'b0, 1'b1, 16'hA1, 1'b0, 1'b1);
    tbl[10] = v(1'b0, 1'b0, 16'h0,  1'b0, 1'b1, 16'hA2, 1'b0, 1'b1);
    tbl[11] = v(1'b0, 1'b0, 16'h0,  1'b0, 1'b1, 16'hA3, 1'b0, 1'b1);
    tbl[12] = v(1'b0, 1'b0, 16'h0,  1'b0, 1'b1, 16'hA4, 1'b1, 1'b1);
    tbl[13] = v(1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b0, 1'b0);
    tbl[14] = v(1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_b = 1'b1;

    // 1) plain frame, one row per clock edge
    en_hi = 0;
    for (int unsigned i = 0; i < 15; i++) begin
      start = tbl[i].start;
      dv    = tbl[i].valid;
      dt    = tbl[i].dt;
      step;
      if (en) en_hi++;
      chk($sformatf("t1_en[%0d]", i),   en,    tbl[i].en);
      chk($sformatf("t1_fv[%0d]", i),   fv,    tbl[i].fv);
      chk($sformatf("t1_last[%0d]", i), flast, tbl[i].last);
      chk($sformatf("t1_busy[%0d]", i), busy,  tbl[i].busy);
      chk($sformatf("t1_tmo[%0d]", i),  tmo,   0);
      if (tbl[i].fv) chk($sformatf("t1_fdt[%0d]", i), fdt, tbl[i].fdt);
    end
    chk("t1_en_high_cycles", en_hi, 6);

    // 2) gapped valid during capture
    frm[0] = 16'hB1; frm[1] = 16'hB2; frm[2] = 16'hB3; frm[3] = 16'hB4;
    capture(1'b0 | 1'b1, 1'b0);
    drain(1'b0, 1'b0, 3);

    // 3) ready toggling during drain
    frm[0] = 16'hC1; frm[1] = 16'hC2; frm[2] = 16'hC3; frm[3] = 16'hC4;
    capture(1'b0, 1'b0);
    drain(1'b1, 1'b0, 3);

    // 4) starts while busy are dropped; back-to-back request keeps the enable gap
    frm[0] = 16'hD1; frm[1] = 16'hD2; frm[2] = 16'hD3; frm[3] = 16'hD4;
    capture(1'b0, 1'b1);
    drain(1'b0, 1'b1, 0);
    last_gap = 0;
    frm[0] = 16'hE1; frm[1] = 16'hE2; frm[2] = 16'hE3; frm[3] = 16'hE4;
    capture(1'b0, 1'b0);
    chk("t4_en_gap_ge2", (last_gap >= 2) ? 1 : 0, 1);
    drain(1'b0, 1'b0, 3);

    // 5) producer never answers
`ifdef XXX_REQ_TIMEOUT_EN
    start = 1'b1;
    step;
    start = 1'b0;
    for (int unsigned i = 1; i <= 15; i++) begin
      step;
      chk("t5_wait_en", en, 1);
      chk("t5_wait_tmo", tmo, 0);
    end
    step;
    chk("t5_tmo_set", tmo, 1);
    chk("t5_en_low", en, 0);
    chk("t5_busy_rel", busy, 1);
    for (int unsigned i = 0; i < 2; i++) begin
      step;
      chk("t5_rel_busy", busy, 1);
      chk("t5_rel_fv", fv, 0);
    end
    step;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_fv", fv, 0);
    step;
    chk("t5_tmo_sticky", tmo, 1);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("t5_tmo_cleared", tmo, 0);
    chk("t5_restart_en", en, 1);
    reset_pulse("t5_rst");
`else
    start = 1'b1;
    step;
    start = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      step;
      chk("t5_wait_en", en, 1);
      chk("t5_wait_tmo", tmo, 0);
      chk("t5_wait_fv", fv, 0);
    end
    chk("t5_still_busy", busy, 1);
    reset_pulse("t5_rst");
`endif

    // 6) reset in the middle of capture, then a clean frame
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    dv = 1'b1; dt = 16'h0F01;
    step;
    dt = 16'h0F02;
    step;
    chk("t6_in_capt_en", en, 1);
    reset_pulse("t6_rst");
    step;
    check_reset_outputs("t6_after");
    frm[0] = 16'h6001; frm[1] = 16'h6002; frm[2] = 16'h6003; frm[3] = 16'h6004;
    capture(1'b0, 1'b0);
    drain(1'b0, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
